// File: rtl/gen_rate_ctrl.sv
// -----------------------------------------------------------------------------
// gen_rate_ctrl
//
// Purpose:
//   Link-rate (Gen1..Gen5) switch controller for a PIPE-style datapath.
//   A legal rate request different from the active rate holds the packet
//   decoder. The controller waits for the decoder to drain and switches the
//   rate. It then keeps the hold for a settle period before releasing it and
//   acknowledging the request. The byte-lane valid mask for the active rate is
//   decoded combinationally from the registered rate code.
//
// Optional feature (macro GEN_RATE_CTRL_TIMEOUT_EN):
//   When defined, the HOLD state counts cycles with pd_idle low. After
//   TIMEOUT_CYCLES such cycles it forces the switch and pulses err_timeout.
//   When undefined, HOLD waits indefinitely and err_timeout is tied low.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-low reset
//   gen_req      in   3   requested rate code, 000=Gen1 .. 100=Gen5
//   gen_req_vld  in   1   one-cycle strobe qualifying gen_req
//   pd_idle      in   1   packet decoder drained (level)
//   hld_pd_gen   out  1   hold to packet decoder (1=hold)
//   gen          out  3   active rate code
//   tx_valid     out  64  byte-lane valid mask for the active rate
//   gen_ack      out  1   one-cycle pulse when a request completes
//   busy         out  1   high in every state except RUN
//   err_bad_gen  out  1   one-cycle pulse on an illegal rate code
//   err_timeout  out  1   one-cycle pulse on a drain timeout
// -----------------------------------------------------------------------------
module gen_rate_ctrl #(
   parameter int GEN1_PIPEWIDTH = 8,
   parameter int GEN2_PIPEWIDTH = 16,
   parameter int GEN3_PIPEWIDTH = 32,
   parameter int GEN4_PIPEWIDTH = 8,
   parameter int GEN5_PIPEWIDTH = 8,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  gen_req,
   input  logic        gen_req_vld,
   input  logic        pd_idle,
   output logic        hld_pd_gen,
   output logic [2:0]  gen,
   output logic [63:0] tx_valid,
   output logic        gen_ack,
   output logic        busy,
   output logic        err_bad_gen,
   output logic        err_timeout
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_SWITCH = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

   localparam logic [2:0] GEN_MAX     = 3'd4;
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   // Lanes = (width * 16) / 8, clamped to the 64-lane bus. The arithmetic is
   // done in int so wide PIPE widths cannot wrap before the clamp.
   function automatic logic [7:0] lane_count(input int width);
      int lanes;
      lanes = (width * 16) / 8;
      if (lanes > 64) begin
         lanes = 64;
      end
      if (lanes < 0) begin
         lanes = 0;
      end
      return 8'(lanes);
   endfunction

   localparam logic [7:0] LANES_G1 = lane_count(GEN1_PIPEWIDTH);
   localparam logic [7:0] LANES_G2 = lane_count(GEN2_PIPEWIDTH);
   localparam logic [7:0] LANES_G3 = lane_count(GEN3_PIPEWIDTH);
   localparam logic [7:0] LANES_G4 = lane_count(GEN4_PIPEWIDTH);
   localparam logic [7:0] LANES_G5 = lane_count(GEN5_PIPEWIDTH);

   // Elaboration-time guard on the counter parameters (both use 8-bit counters).
   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
          TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
         $error("gen_rate_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be 1..255");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0] state_reg,  state_next;
   logic [7:0] cnt_reg,    cnt_next;
   logic [2:0] gen_reg,    gen_next;
   logic [2:0] target_reg, target_next;
   logic       hld_reg,    hld_next;
   logic       busy_reg,   busy_next;
   logic       ack_reg,    ack_next;
   logic       bad_reg,    bad_next;
   // Set only by a real switch. The settle period that follows reset reuses
   // SETTLE but must not acknowledge anything.
   logic       armed_reg,  armed_next;

`ifdef GEN_RATE_CTRL_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] to_cnt_reg, to_cnt_next;
   logic       tout_reg,   tout_next;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      gen_next    = gen_reg;
      target_next = target_reg;
      ack_next    = 1'b0;
      bad_next    = 1'b0;
      armed_next  = armed_reg;
`ifdef GEN_RATE_CTRL_TIMEOUT_EN
      to_cnt_next = to_cnt_reg;
      tout_next   = 1'b0;
`endif

      case (state_reg)
         ST_RUN: begin
`ifdef GEN_RATE_CTRL_TIMEOUT_EN
            to_cnt_next = 8'd0;
`endif
            if (gen_req_vld) begin
               if (gen_req > GEN_MAX) begin
                  bad_next = 1'b1;
               end else if (gen_req == gen_reg) begin
                  ack_next = 1'b1;
               end else begin
                  target_next = gen_req;
                  state_next  = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (pd_idle) begin
               state_next = ST_SWITCH;
            end
`ifdef GEN_RATE_CTRL_TIMEOUT_EN
            else if (to_cnt_reg >= TIMEOUT_LAST) begin
               // This is the TIMEOUT_CYCLES-th undrained cycle, so force the switch.
               state_next = ST_SWITCH;
               tout_next  = 1'b1;
            end else begin
               to_cnt_next = to_cnt_reg + 8'd1;
            end
`endif
         end

         ST_SWITCH: begin
            gen_next   = target_reg;
            cnt_next   = SETTLE_LOAD;
            armed_next = 1'b1;
            state_next = ST_SETTLE;
         end

         default: begin // ST_SETTLE
            cnt_next = cnt_reg - 8'd1;
            // The <= also covers 0, so a corrupted counter cannot spin forever.
            if (cnt_reg <= 8'd1) begin
               state_next = ST_RUN;
               ack_next   = armed_reg;
               armed_next = 1'b0;
            end
         end
      endcase

      // hld and busy are registered from the next state. This makes them
      // glitch-free and gives them exact state alignment.
      hld_next  = (state_next != ST_RUN);
      busy_next = (state_next != ST_RUN);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= ST_SETTLE;
         cnt_reg    <= SETTLE_LOAD;
         gen_reg    <= 3'd0;
         target_reg <= 3'd0;
         hld_reg    <= 1'b1;
         busy_reg   <= 1'b1;
         ack_reg    <= 1'b0;
         bad_reg    <= 1'b0;
         armed_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         gen_reg    <= gen_next;
         target_reg <= target_next;
         hld_reg    <= hld_next;
         busy_reg   <= busy_next;
         ack_reg    <= ack_next;
         bad_reg    <= bad_next;
         armed_reg  <= armed_next;
      end
   end

`ifdef GEN_RATE_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_reg <= 8'd0;
         tout_reg   <= 1'b0;
      end else begin
         to_cnt_reg <= to_cnt_next;
         tout_reg   <= tout_next;
      end
   end

   assign err_timeout = tout_reg;
`else
   assign err_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Lane-valid decode (combinational from registered gen)
   // ---------------------------------------------------------------------------
   logic [7:0] lane_cnt;

   always_comb begin
      case (gen_reg)
         3'd1:    lane_cnt = LANES_G2;
         3'd2:    lane_cnt = LANES_G3;
         3'd3:    lane_cnt = LANES_G4;
         3'd4:    lane_cnt = LANES_G5;
         default: lane_cnt = LANES_G1;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 64; gi++) begin : g_lane
         assign tx_valid[gi] = (lane_cnt > 8'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign hld_pd_gen  = hld_reg;
   assign gen         = gen_reg;
   assign gen_ack     = ack_reg;
   assign busy        = busy_reg;
   assign err_bad_gen = bad_reg;

endmodule
